// File: rtl/sync_fifo_ctrl.sv
// Pointer/flag controller for a synchronous FIFO on a dual-port RAM:
// port 0 is write-only, port 1 is read-only with 1-cycle read latency.
module sync_fifo_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic                  ram_cen_0_o,
    output logic                  ram_wen_0_o,
    output logic [ADDR_WIDTH-1:0] ram_a_0_o,
    output logic [DATA_WIDTH-1:0] ram_d_0_o,
    output logic                  ram_cen_1_o,
    output logic                  ram_wen_1_o,
    output logic [ADDR_WIDTH-1:0] ram_a_1_o,
    input  logic [DATA_WIDTH-1:0] ram_q_1_i
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  af_q, af_d, ae_q, ae_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  rd_valid_q;
    logic                  wr_acc, rd_acc;

    // Accepts are masked during reset so the RAM stays deselected.
    always_comb begin
        rd_acc = rd_en_i & ~empty_q & ~rst_i;
        wr_acc = wr_en_i & (~full_q | rd_acc) & ~rst_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CNT_W'(AF_LEVEL));
        ae_d    = (count_d <= CNT_W'(AE_LEVEL));
        ovf_d   = ovf_q | (wr_en_i & full_q & ~rd_acc);
        udf_d   = udf_q | (rd_en_i & empty_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rd_valid_q <= rd_acc;
        end
    end

    assign rd_data_o      = ram_q_1_i;
    assign rd_valid_o     = rd_valid_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;
    assign ram_cen_0_o    = ~wr_acc;
    assign ram_wen_0_o    = ~wr_acc;
    assign ram_a_0_o      = wr_ptr_q;
    assign ram_d_0_o      = wr_data_i;
    assign ram_cen_1_o    = ~rd_acc;
    assign ram_wen_1_o    = 1'b1;
    assign ram_a_1_o      = rd_ptr_q;
endmodule
